// File: rtl/button_keyboard.sv
// Monophonic 8-key front end: debounces active-low buttons on the sample tick, picks the
// lowest held key and drives oscillator increment, envelope gate and note. Glide: BUTTON_KEYBOARD_GLIDE_EN.
module button_keyboard #(
    parameter int DEBOUNCE_TICKS = 64
`ifdef BUTTON_KEYBOARD_GLIDE_EN
    , parameter int GLIDE_STEP = 64
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_clock,
    input  logic [7:0]  btn,
    output logic [20:0] increment,
    output logic        gate,
    output logic [2:0]  note
);

    localparam logic [7:0] DbLast = 8'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StRetrig} state_t;

    state_t      state_q, state_d;
    logic [7:0]  btn_s1_q, btn_s2_q, accepted_q;
    logic [7:0]  cnt_q [8];
    logic        sclk_q, sclk_prev_q, tick;
    logic [7:0]  held;
    logic        any_held;
    logic [2:0]  key;
    logic [20:0] increment_d;
    logic [2:0]  note_d;
    logic        gate_d;

    function automatic logic [20:0] target(input logic [2:0] k);
        unique case (k)
            3'd0: target = 21'd17582;
            3'd1: target = 21'd19729;
            3'd2: target = 21'd22145;
            3'd3: target = 21'd23420;
            3'd4: target = 21'd26306;
            3'd5: target = 21'd29527;
            3'd6: target = 21'd33151;
            default: target = 21'd35097;
        endcase
    endfunction

`ifdef BUTTON_KEYBOARD_GLIDE_EN
    // Step toward tgt, landing exactly on it once within one step.
    function automatic logic [20:0] glide(input logic [20:0] cur, input logic [20:0] tgt);
        logic signed [21:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > $signed(22'(GLIDE_STEP)))       glide = cur + 21'(GLIDE_STEP);
        else if (diff < -$signed(22'(GLIDE_STEP))) glide = cur - 21'(GLIDE_STEP);
        else                                        glide = tgt;
    endfunction
`endif

    assign tick = sclk_q & ~sclk_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q    <= '1;
            btn_s2_q    <= '1;
            accepted_q  <= '1;
            sclk_q      <= 1'b0;
            sclk_prev_q <= 1'b0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            btn_s1_q    <= btn;
            btn_s2_q    <= btn_s1_q;
            sclk_q      <= sample_clock;
            sclk_prev_q <= sclk_q;
            if (tick) begin
                for (int i = 0; i < 8; i++) begin
                    if (btn_s2_q[i] == accepted_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == DbLast) begin
                        accepted_q[i] <= btn_s2_q[i];
                        cnt_q[i]      <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 8'd1;
                    end
                end
            end
        end
    end

    assign held     = ~accepted_q;
    assign any_held = |held;

    always_comb begin
        key = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (held[i]) key = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            increment <= '0;
            gate      <= 1'b0;
            note      <= '0;
        end else begin
            state_q   <= state_d;
            increment <= increment_d;
            gate      <= gate_d;
            note      <= note_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                StIdle:   if (any_held) state_d = StPlay;
                StPlay: begin
                    if (!any_held)        state_d = StIdle;
                    else if (key != note) state_d = StRetrig;
                end
                default:  state_d = any_held ? StPlay : StIdle;
            endcase
        end
    end

    // Released notes keep increment/note for the envelope's release tail.
    always_comb begin
        increment_d = increment;
        note_d      = note;
        gate_d      = gate;
        if (tick) begin
            gate_d = (state_d == StPlay);
            if (any_held) begin
                note_d = key;
                if (state_q == StIdle) begin
                    increment_d = target(key);
                end else begin
`ifdef BUTTON_KEYBOARD_GLIDE_EN
                    increment_d = glide(increment, target(key));
`else
                    increment_d = target(key);
`endif
                end
            end
        end
    end

endmodule
